// File: rtl/l2_chan_fifo_bank.sv
// rtl/l2_chan_fifo_bank.sv - bank of independent per-channel elastic FIFOs
// Define L2_CHAN_STATS_EN to build the per-channel high-water/stall statistics unit.
module l2_chan_fifo_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int HWM_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     stats_req,
  output logic                     stats_valid,
  input  logic                     stats_ready,
  output logic [CH_W-1:0]          stats_ch,
  output logic [HWM_W-1:0]         stats_hwm,
  output logic [CNT_W-1:0]         stats_stall
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [DATA_W-1:0] mem_d    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [HWM_W-1:0]  count_q  [NUM_CH];
  logic [HWM_W-1:0]  count_d  [NUM_CH];
  logic [NUM_CH-1:0] in_ready_q, in_ready_d;
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic [NUM_CH-1:0] push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // Both handshake flags are registered from the next count, so out_ready never reaches in_ready.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_ready_d  = '0;
    out_valid_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = in_data[c*DATA_W +: DATA_W];
        wr_ptr_d[c]           = wr_ptr_q[c] + PTR_W'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
      end
      case ({push[c], pop[c]})
        2'b10:   count_d[c] = count_q[c] + HWM_W'(1);
        2'b01:   count_d[c] = count_q[c] - HWM_W'(1);
        default: count_d[c] = count_q[c];
      endcase
      in_ready_d[c]  = (count_d[c] < HWM_W'(DEPTH));
      out_valid_d[c] = (count_d[c] != '0);
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_data[c*DATA_W +: DATA_W] = out_valid_q[c] ? mem_q[c][rd_ptr_q[c]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      count_q     <= '{default: '0};
      in_ready_q  <= '0;
      out_valid_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef L2_CHAN_STATS_EN
  typedef enum logic {S_IDLE, S_SEND} stats_state_e;

  stats_state_e     state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [HWM_W-1:0] hwm_q       [NUM_CH];
  logic [HWM_W-1:0] hwm_d       [NUM_CH];
  logic [CNT_W-1:0] stall_q     [NUM_CH];
  logic [CNT_W-1:0] stall_d     [NUM_CH];
  logic [HWM_W-1:0] shd_hwm_q   [NUM_CH];
  logic [HWM_W-1:0] shd_hwm_d   [NUM_CH];
  logic [CNT_W-1:0] shd_stall_q [NUM_CH];
  logic [CNT_W-1:0] shd_stall_d [NUM_CH];
  logic             snap;
  logic [HWM_W-1:0] hwm_base;
  logic [CNT_W-1:0] stall_base;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shd_hwm_d   = shd_hwm_q;
    shd_stall_d = shd_stall_q;
    snap        = 1'b0;
    stats_valid = 1'b0;
    stats_ch    = '0;
    stats_hwm   = '0;
    stats_stall = '0;
    hwm_base    = '0;
    stall_base  = '0;
    hwm_d       = hwm_q;
    stall_d     = stall_q;
    case (state_q)
      S_IDLE: begin
        if (stats_req) begin
          snap        = 1'b1;
          state_d     = S_SEND;
          idx_d       = '0;
          shd_hwm_d   = hwm_q;
          shd_stall_d = stall_q;
        end
      end
      S_SEND: begin
        stats_valid = 1'b1;
        stats_ch    = idx_q;
        stats_hwm   = shd_hwm_q[idx_q];
        stats_stall = shd_stall_q[idx_q];
        if (stats_ready) begin
          if (idx_q == CH_W'(NUM_CH - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A snapshot cycle restarts the live counters but still counts that cycle's own event.
    for (int c = 0; c < NUM_CH; c++) begin
      hwm_base   = snap ? '0 : hwm_q[c];
      stall_base = snap ? '0 : stall_q[c];
      stall_d[c] = (in_valid[c] && !in_ready_q[c] && (stall_base != '1))
                   ? stall_base + CNT_W'(1) : stall_base;
      hwm_d[c]   = (count_d[c] > hwm_base) ? count_d[c] : hwm_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hwm_q       <= '{default: '0};
      stall_q     <= '{default: '0};
      shd_hwm_q   <= '{default: '0};
      shd_stall_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hwm_q       <= hwm_d;
      stall_q     <= stall_d;
      shd_hwm_q   <= shd_hwm_d;
      shd_stall_q <= shd_stall_d;
    end
  end
`else
  logic unused_stats;

  assign unused_stats = stats_req ^ stats_ready;
  assign stats_valid  = 1'b0;
  assign stats_ch     = '0;
  assign stats_hwm    = '0;
  assign stats_stall  = '0;
`endif

endmodule
